// File: rtl/sfp_event_tx_manager.sv
// Event transmit framer: once every channel holds an unsent event, reads one event per channel
// and sends HDR, EVN, payload, TRL, then idle gap. Optional TX_CHECKSUM_EN puts a sum in the trailer.
module sfp_event_tx_manager #(
  parameter int unsigned WORDS_PER_EVT = 4,
  parameter int unsigned IFG           = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        need_read,
  input  logic        need_check,
  output logic        rd_en,
  output logic [3:0]  ch_sel,
  input  logic [15:0] rd_data,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_k,
  output logic [15:0] evt_tx,
  output logic        busy
);

  localparam int unsigned NCH    = 16;
  localparam int unsigned NWORDS = NCH * WORDS_PER_EVT;
  localparam int unsigned DCW    = $clog2(NWORDS + 1);
  localparam int unsigned WW     = (WORDS_PER_EVT > 1) ? $clog2(WORDS_PER_EVT) : 1;
  localparam int unsigned GW     = $clog2(IFG + 1);

  localparam logic [15:0] IDLE_WORD = 16'h50BC;
  localparam logic [15:0] HDR_WORD  = 16'hA5BC;
  localparam logic [15:0] TRL_WORD  = 16'hE0E0;
  localparam logic [1:0]  K_COMMA   = 2'b01;
  localparam logic [1:0]  K_DATA    = 2'b00;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_EVN, S_DATA, S_TRL, S_GAP} state_t;

  state_t          state_q;
  logic [DCW-1:0]  dcnt_q;
  logic [WW-1:0]   wd_q;
  logic [GW-1:0]   gcnt_q;
  logic [15:0]     trl_word;

  // need_check is reserved for a strict-check mode that this block never builds
  logic unused_need_check;
  assign unused_need_check = need_check;

  // Read sequencer: runs two cycles ahead of tx_data, starting on the edge that leaves IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en  <= 1'b0;
      ch_sel <= 4'd0;
      wd_q   <= '0;
    end else if (state_q == S_IDLE && need_read) begin
      rd_en  <= 1'b1;
      ch_sel <= 4'd0;
      wd_q   <= '0;
    end else if (rd_en) begin
      if (wd_q == WW'(WORDS_PER_EVT - 1)) begin
        wd_q <= '0;
        if (ch_sel == 4'(NCH - 1)) rd_en <= 1'b0;
        else                       ch_sel <= ch_sel + 4'd1;
      end else begin
        wd_q <= wd_q + WW'(1);
      end
    end
  end

  // Frame FSM: state_q names the word currently on tx_data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tx_data <= IDLE_WORD;
      tx_k    <= K_COMMA;
      evt_tx  <= 16'd0;
      busy    <= 1'b0;
      dcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_data <= IDLE_WORD;
          tx_k    <= K_COMMA;
          if (need_read) begin
            state_q <= S_HDR;
            tx_data <= HDR_WORD;
            busy    <= 1'b1;
          end
        end
        S_HDR: begin
          state_q <= S_EVN;
          tx_data <= evt_tx;
          tx_k    <= K_DATA;
        end
        S_EVN: begin
          state_q <= S_DATA;
          tx_data <= rd_data;
          dcnt_q  <= DCW'(1);
        end
        S_DATA: begin
          if (dcnt_q == DCW'(NWORDS)) begin
            state_q <= S_TRL;
            tx_data <= trl_word;
          end else begin
            tx_data <= rd_data;
            dcnt_q  <= dcnt_q + DCW'(1);
          end
        end
        S_TRL: begin
          state_q <= S_GAP;
          tx_data <= IDLE_WORD;
          tx_k    <= K_COMMA;
          evt_tx  <= evt_tx + 16'd1;
          gcnt_q  <= GW'(1);
        end
        S_GAP: begin
          if (gcnt_q == GW'(IFG)) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_data <= IDLE_WORD;
          tx_k    <= K_COMMA;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef TX_CHECKSUM_EN
  logic [15:0] csum_q;

  // Sum of the EVN word and every payload word, loaded with the event number in HDR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 16'd0;
    end else if (state_q == S_HDR) begin
      csum_q <= evt_tx;
    end else if (state_q == S_EVN || (state_q == S_DATA && dcnt_q != DCW'(NWORDS))) begin
      csum_q <= csum_q + rd_data;
    end
  end

  assign trl_word = csum_q;
`else
  assign trl_word = TRL_WORD;
`endif

endmodule

// File: tb/tb_sfp_event_tx_manager.sv
// Bench for sfp_event_tx_manager: vector table, random need_read traffic against a frame-offset
// model, and hand sequences for mid-frame reset, back-to-back, counter wrap and trailer value.
module tb_sfp_event_tx_manager;

  localparam int W     = 4;
  localparam int IFG_C = 4;
  localparam int N     = 16 * W;
`ifdef TX_CHECKSUM_EN
  localparam logic [15:0] TBL_TRL = 16'hE060;
  localparam logic [15:0] EV5_TRL = 16'h0045;
`else
  localparam logic [15:0] TBL_TRL = 16'hE0E0;
  localparam logic [15:0] EV5_TRL = 16'hE0E0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, need_read, need_check, rd_en, busy;
  logic [3:0]  ch_sel;
  logic [15:0] rd_data, tx_data, evt_tx;
  logic [1:0]  tx_k;

  always #5 clk = ~clk;

  sfp_event_tx_manager #(.WORDS_PER_EVT(W), .IFG(IFG_C)) dut (
    .clk(clk), .reset_n(reset_n), .need_read(need_read), .need_check(need_check),
    .rd_en(rd_en), .ch_sel(ch_sel), .rd_data(rd_data), .tx_data(tx_data),
    .tx_k(tx_k), .evt_tx(evt_tx), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model: data appears one clock after rd_en; every read is logged with its mode
  typedef struct {logic [1:0] m; logic [15:0] v;} rd_rec_t;
  rd_rec_t    rdq[$];
  int         wc[16];
  logic [1:0] mode = 2'd0;

  function automatic logic [15:0] fifo_val(input logic [1:0] m, input logic [3:0] c, input int w);
    case (m)
      2'd0:    return {4'h0, c, 8'(w)};
      2'd1:    return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 16; c++) wc[c] <= 0;
      rdq.delete();
      rd_data <= 16'hDEAD;
    end else if (rd_en) begin
      rdq.push_back(rd_rec_t'{mode, fifo_val(mode, ch_sel, wc[ch_sel])});
      rd_data <= rdq[$].v;
      wc[ch_sel] <= (wc[ch_sel] + 1) % W;
    end else begin
      rd_data <= 16'hDEAD;
    end
  end

  // Reference model: off = position of the word on tx_data within the frame (0 = idle)
  int          off = 0;
  int          cyc = 0;
  logic [15:0] m_evt = 16'd0, m_evn = 16'd0, m_sum = 16'd0, last_trl = 16'd0;
  int          hdr_q[$];
  logic [15:0] evn_q[$];
  bit          grab_evn = 1'b0;

  task automatic check_now();
    logic [15:0] e_tx;
    logic [1:0]  e_k;
    rd_rec_t     r;
    int          i;
    e_tx = 16'h50BC;
    e_k  = 2'b01;
    if (off == 1) begin
      e_tx = 16'hA5BC;
    end else if (off == 2) begin
      e_tx  = m_evn;
      e_k   = 2'b00;
      m_sum = m_evn;
    end else if (off >= 3 && off <= N + 2) begin
      i   = off - 3;
      e_k = 2'b00;
      if (rdq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_log: no FIFO read logged for payload word %0d", i);
        e_tx = 16'hDEAD;
      end else begin
        r = rdq.pop_front();
        if (r.m == 2'd0)      e_tx = {4'h0, 4'(i / W), 8'(i % W)};
        else if (r.m == 2'd1) e_tx = 16'h0001;
        else                  e_tx = r.v;
      end
      m_sum = m_sum + e_tx;
    end else if (off == N + 3) begin
      e_k = 2'b00;
`ifdef TX_CHECKSUM_EN
      e_tx = m_sum;
`else
      e_tx = 16'hE0E0;
`endif
      last_trl = tx_data;
    end
    chk($sformatf("tx_data@off%0d", off), 32'(tx_data), 32'(e_tx));
    chk($sformatf("tx_k@off%0d", off), 32'(tx_k), 32'(e_k));
    chk($sformatf("rd_en@off%0d", off), 32'(rd_en), 32'(off >= 1 && off <= N));
    chk($sformatf("busy@off%0d", off), 32'(busy), 32'(off != 0));
    chk($sformatf("evt_tx@off%0d", off), 32'(evt_tx), 32'(m_evt));
    if (off >= 1 && off <= N) chk($sformatf("ch_sel@off%0d", off), 32'(ch_sel), 32'((off - 1) / W));
    if (grab_evn) evn_q.push_back(tx_data);
    grab_evn = (tx_data == 16'hA5BC && tx_k == 2'b01);
    if (grab_evn) hdr_q.push_back(cyc);
  endtask

  task automatic step(input bit nr, input bit nc);
    check_now();
    need_read  = nr;
    need_check = nc;
    if (off == 0) begin
      if (nr) begin
        off   = 1;
        m_evn = m_evt;
      end
    end else begin
      if (off == N + 3) m_evt = m_evt + 16'd1;
      off = (off == N + 3 + IFG_C) ? 0 : off + 1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to_idle(input int max);
    int k;
    k = 0;
    while (off != 0 && k < max) begin
      step(1'b0, 1'b0);
      k++;
    end
    chk("idle_timeout", 32'(off), 32'd0);
  endtask

  typedef struct {
    bit nr; bit nc; int cycles;
    logic [15:0] tx; logic [1:0] k; bit rd; logic [3:0] ch;
    logic [15:0] evt; bit busy; int reads;
  } vec_t;
  vec_t tbl[14];

  bit nrv;
  int hold;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    need_read  = 1'b0;
    need_check = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 32'h50BC);
    chk("rst_tx_k", 32'(tx_k), 32'h1);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_ch_sel", 32'(ch_sel), 32'h0);
    chk("rst_evt_tx", 32'(evt_tx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;

    // nr nc cyc  tx        k      rd ch  evt busy reads
    tbl[0]  = '{0, 0,   3, 16'h50BC, 2'b01, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 1, 100, 16'h50BC, 2'b01, 0, 0,  0, 0, 0};
    tbl[2]  = '{0, 1, 100, 16'h50BC, 2'b01, 0, 0,  0, 0, 0};
    tbl[3]  = '{1, 0,   1, 16'hA5BC, 2'b01, 1, 0,  0, 1, 1};
    tbl[4]  = '{0, 0,   1, 16'h0000, 2'b00, 1, 0,  0, 1, 1};
    tbl[5]  = '{0, 0,   1, 16'h0000, 2'b00, 1, 0,  0, 1, 1};
    tbl[6]  = '{0, 0,   1, 16'h0001, 2'b00, 1, 0,  0, 1, 1};
    tbl[7]  = '{0, 1,  60, 16'h0F01, 2'b00, 1, 15, 0, 1, 60};
    tbl[8]  = '{0, 0,   1, 16'h0F02, 2'b00, 0, 0,  0, 1, 0};
    tbl[9]  = '{0, 0,   1, 16'h0F03, 2'b00, 0, 0,  0, 1, 0};
    tbl[10] = '{0, 0,   1, TBL_TRL,  2'b00, 0, 0,  0, 1, 0};
    tbl[11] = '{0, 0,   1, 16'h50BC, 2'b01, 0, 0,  1, 1, 0};
    tbl[12] = '{0, 0,   3, 16'h50BC, 2'b01, 0, 0,  1, 1, 0};
    tbl[13] = '{0, 0,   1, 16'h50BC, 2'b01, 0, 0,  1, 0, 0};

    for (int v = 0; v < 14; v++) begin
      int rc;
      rc = 0;
      for (int j = 0; j < tbl[v].cycles; j++) begin
        need_read  = tbl[v].nr;
        need_check = tbl[v].nc && (j % 3 == 0);
        @(negedge clk);
        if (rd_en) rc++;
      end
      need_read  = 1'b0;
      need_check = 1'b0;
      chk($sformatf("vec%0d_tx_data", v), 32'(tx_data), 32'(tbl[v].tx));
      chk($sformatf("vec%0d_tx_k", v), 32'(tx_k), 32'(tbl[v].k));
      chk($sformatf("vec%0d_rd_en", v), 32'(rd_en), 32'(tbl[v].rd));
      chk($sformatf("vec%0d_evt_tx", v), 32'(evt_tx), 32'(tbl[v].evt));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      chk($sformatf("vec%0d_reads", v), 32'(rc), 32'(tbl[v].reads));
      if (tbl[v].rd) chk($sformatf("vec%0d_ch_sel", v), 32'(ch_sel), 32'(tbl[v].ch));
    end

    // Random need_read/need_check traffic with random payload modes
    off   = 0;
    m_evt = 16'd1;
    rdq.delete();
    hold  = 0;
    nrv   = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (hold == 0) begin
        nrv  = ($urandom_range(0, 2) != 0);
        hold = $urandom_range(1, 150);
      end
      hold--;
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 2));
      step(nrv, $urandom_range(0, 7) == 0);
    end
    run_to_idle(200);

    // Reset asserted while payload word 20 is on tx_data
    mode = 2'd0;
    step(1'b1, 1'b0);
    begin
      int k;
      k = 0;
      while (off != 23 && k < 100) begin
        step(1'b0, 1'b0);
        k++;
      end
    end
    check_now();
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_data", 32'(tx_data), 32'h50BC);
    chk("midrst_tx_k", 32'(tx_k), 32'h1);
    chk("midrst_rd_en", 32'(rd_en), 32'h0);
    chk("midrst_evt_tx", 32'(evt_tx), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    off   = 0;
    m_evt = 16'd0;
    grab_evn = 1'b0;
    hdr_q.delete();
    evn_q.delete();
    cyc = 0;

    // Back-to-back with need_read held high
    for (int t = 0; t < 3 * (N + 4 + IFG_C) + 4; t++) step(1'b1, 1'b0);
    run_to_idle(200);
    chk("b2b_frames", 32'(hdr_q.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (hdr_q.size() > i + 1)
        chk($sformatf("b2b_period%0d", i), 32'(hdr_q[i+1] - hdr_q[i]), 32'(N + 3 + IFG_C + 1));
      if (evn_q.size() > i)
        chk($sformatf("b2b_evn%0d", i), 32'(evn_q[i]), 32'(i));
    end

    // Counter wrap through a backdoor preset of evt_tx
    force dut.evt_tx = 16'hFFFF;
    m_evt = 16'hFFFF;
    @(negedge clk);
    release dut.evt_tx;
    step(1'b1, 1'b0);
    run_to_idle(200);
    chk("wrap_evt_tx", 32'(evt_tx), 32'h0);

    // Trailer of event number 5 with an all-ones payload
    mode = 2'd1;
    for (int f = 0; f < 6; f++) begin
      step(1'b1, 1'b0);
      run_to_idle(200);
    end
    chk("trailer_evn5", 32'(last_trl), 32'(EV5_TRL));
    chk("evt_after_6", 32'(evt_tx), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
